rtc_bus_burst: RTL and testbench
================================

Name: rtc_bus_burst

Overview:
- Parametrised master for the RTC's multiplexed address/data bus (AD, WR, RD, CS, active-low strobes).
- Runs a burst read or write of 1..NREG consecutive RTC registers from a single start request, with programmable phase timing.
- Replaces the fixed per-sequence bus generators (init, time/date/timer read and write); those FSMs issue register lists through it instead of hand-coding strobes.
- Its bus outputs feed the existing bus multiplexer as one more source.

Parameters:
- DW, 8: bus/data width.
- NREG, 4: maximum registers per burst; depth of the read/write buffers.
- CW, 3: width of the count port; must hold NREG.
- T_SETUP, 2: cycles from a phase start to strobe assertion (≥1).
- T_STROBE, 4: cycles the WR/RD strobe is held low (≥1).
- T_HOLD, 2: cycles after strobe release before the phase ends (≥1).
- T_GAP, 2: cycles CS is high between registers (≥1).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- start  in  1  one-cycle request; sampled only when busy=0.
- wr_nrd  in  1  1=write burst, 0=read burst; latched with start.
- base_addr  in  DW  first RTC register address; latched with start.
- count  in  CW  number of registers; latched with start.
- wdata  in  NREG*DW  write data; slot i at [i*DW +: DW]; latched with start.
- rdata  out  NREG*DW  read buffer; slot i holds register base_addr+i.
- busy  out  1  high while a burst is in progress.
- done  out  1  one-cycle pulse at burst end.
- ADin  in  DW  bus input.
- ADout  out  DW  bus output value.
- Pullup  out  1  bus output enable; 1=drive ADout, 0=release the bus.
- AD  out  1  phase select; 0=address phase, 1=data phase.
- WR  out  1  write strobe, active-low.
- RD  out  1  read strobe, active-low.
- CS  out  1  chip select, active-low.

Behaviour:
- All outputs are registered.
- Reset values: CS=WR=RD=AD=1, Pullup=0, ADout=0, busy=0, done=0, rdata=0.
- Reset mid-burst: outputs return to reset values on the same edge, the burst is abandoned, rdata is cleared, no done pulse.
- Start accepted at edge k (start=1, busy=0):
  - latch wr_nrd, base_addr, wdata and n=min(count,NREG);
  - from k+1: busy=1, CS=0.
- start while busy=1 is ignored; latched inputs are unaffected.
- n=0: no bus activity; done=1 at k+1 only; busy stays 0.
- FSM states: IDLE, A_SETUP, A_STROBE, A_HOLD, D_SETUP, D_STROBE, D_HOLD, GAP, DONE.
  - Each timed state runs its T_* cycles using a single down-counter.
- Register i of the burst uses address (base_addr+i) mod 2^DW; wrap past 2^DW-1 is allowed.
- Address phase (A_*): AD=0, Pullup=1, ADout=address. WR=0 during A_STROBE, otherwise 1. RD=1.
- Data phase, write (D_*): AD=1, Pullup=1, ADout=wdata slot i. WR=0 during D_STROBE. RD=1.
- Data phase, read (D_*): AD=1, Pullup=0, ADout=0. RD=0 during D_STROBE; WR=1.
  - ADin is captured into rdata slot i on the last D_STROBE cycle, i.e. the cycle before RD rises.
- CS=0 from A_SETUP through D_HOLD; CS=1 in GAP.
- After GAP: if i<n-1, go to A_SETUP with i+1; else go to DONE.
- DONE lasts one cycle: done=1, busy=0; all bus signals are idle. The FSM then returns to IDLE.
  - A start in the DONE cycle is accepted.
- Per-register period P = 2*(T_SETUP+T_STROBE+T_HOLD)+T_GAP = 18 cycles with defaults.
- done rises at k+1+n*P.
- rdata slots not touched by a read burst retain their previous value. Write bursts never modify rdata.
- WR and RD are never low simultaneously. Strobes are never low while CS=1.

Test Plan:
- Write, base_addr=0x21, count=3, wdata slots 0x12,0x34,0x56 -> three CS frames at addresses 0x21,0x22,0x23; data 0x12,0x34,0x56; Pullup=1 throughout; done at k+55.
- Read, base_addr=0x41, count=4, bus model returns 0xA0+addr -> rdata = {0xE4,0xE3,0xE2,0xE1} (slot3..slot0); Pullup=0 in every data phase.
- count=0 -> done at k+1; CS stays 1; busy never asserts.
- count=7 (NREG=4) -> exactly 4 frames; done at k+73.
- base_addr=0xFF, count=2, write -> addresses 0xFF then 0x00.
- Second start mid-burst ignored; rst asserted during D_STROBE of register 1 -> next edge CS=WR=RD=1, busy=0, rdata=0, no done; a new burst then runs normally.

Source files
------------

// File: rtl/rtc_bus_burst.sv
// rtc_bus_burst - burst master for the RTC multiplexed address/data bus.
//
// Runs a read or write burst of 1..NREG consecutive RTC registers from a single
// start request. Each register is one CS frame: an address phase (AD=0) with a
// WR strobe, then a data phase (AD=1) with a WR (write) or RD (read) strobe.
// After the frame, CS is high for T_GAP cycles. Each phase has setup, strobe
// and hold sections whose lengths are set by parameters.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start               one-cycle request, accepted only while busy=0
//   wr_nrd              1=write burst, 0=read burst (latched with start)
//   base_addr           first register address (latched with start)
//   count               registers in the burst, saturated to NREG (latched)
//   wdata               write data, slot i at [i*DW +: DW] (latched)
//   rdata               read buffer, slot i holds register base_addr+i
//   busy, done          burst in progress / one-cycle end-of-burst pulse
//   ADin                bus input
//   ADout, Pullup       bus output value and its output enable
//   AD                  phase select, 0=address, 1=data
//   WR, RD, CS          active-low write strobe, read strobe, chip select
module rtc_bus_burst #(
  parameter int DW       = 8,
  parameter int NREG     = 4,
  parameter int CW       = 3,
  parameter int T_SETUP  = 2,
  parameter int T_STROBE = 4,
  parameter int T_HOLD   = 2,
  parameter int T_GAP    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             wr_nrd,
  input  logic [DW-1:0]    base_addr,
  input  logic [CW-1:0]    count,
  input  logic [NREG*DW-1:0] wdata,
  output logic [NREG*DW-1:0] rdata,
  output logic             busy,
  output logic             done,
  input  logic [DW-1:0]    ADin,
  output logic [DW-1:0]    ADout,
  output logic             Pullup,
  output logic             AD,
  output logic             WR,
  output logic             RD,
  output logic             CS
);

  localparam int TMAX_SH = (T_SETUP > T_HOLD) ? T_SETUP : T_HOLD;
  localparam int TMAX_SG = (T_STROBE > T_GAP) ? T_STROBE : T_GAP;
  localparam int TMAX    = (TMAX_SH > TMAX_SG) ? TMAX_SH : TMAX_SG;
  // The down-counter only ever holds T-1, so $clog2(TMAX) bits suffice.
  localparam int CNTW    = (TMAX < 2) ? 1 : $clog2(TMAX);
  localparam int IW      = (NREG < 2) ? 1 : $clog2(NREG);

  typedef enum logic [3:0] {
    IDLE, A_SETUP, A_STROBE, A_HOLD, D_SETUP, D_STROBE, D_HOLD, GAP, DONE
  } state_t;

  state_t              state_q, state_d;
  logic [CNTW-1:0]     cnt_q, cnt_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [CW-1:0]       n_q, n_d;
  logic                dir_wr_q, dir_wr_d;
  logic [DW-1:0]       base_q, base_d;
  logic [NREG*DW-1:0]  wdata_q, wdata_d;
  logic [NREG*DW-1:0]  rdata_q;

  logic                cs_q, cs_d, wr_n_q, wr_n_d, rd_n_q, rd_n_d, ad_q, ad_d;
  logic                pullup_q, pullup_d, busy_q, busy_d, done_q, done_d;
  logic [DW-1:0]       adout_q, adout_d;

  logic [CW-1:0]       n_in;
  logic [CW-1:0]       idx_next_ext;
  logic                accept;
  logic [DW-1:0]       addr_d;
  logic [DW-1:0]       slot_d;

  assign n_in         = (count > CW'(NREG)) ? CW'(NREG) : count;
  assign idx_next_ext = CW'(idx_q) + CW'(1);
  // DONE reports busy=0, so a new start is taken there as well as in IDLE.
  assign accept       = start && ((state_q == IDLE) || (state_q == DONE));

  // Next-state and sequencing
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    n_d      = n_q;
    dir_wr_d = dir_wr_q;
    base_d   = base_q;
    wdata_d  = wdata_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (accept) begin
          dir_wr_d = wr_nrd;
          base_d   = base_addr;
          wdata_d  = wdata;
          n_d      = n_in;
          idx_d    = '0;
          if (n_in == '0) begin
            state_d = DONE;
          end else begin
            state_d = A_SETUP;
            cnt_d   = CNTW'(T_SETUP - 1);
          end
        end
      end
      A_SETUP, A_STROBE, A_HOLD, D_SETUP, D_STROBE, D_HOLD, GAP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNTW'(1);
        end else begin
          case (state_q)
            A_SETUP:  begin state_d = A_STROBE; cnt_d = CNTW'(T_STROBE - 1); end
            A_STROBE: begin state_d = A_HOLD;   cnt_d = CNTW'(T_HOLD - 1);   end
            A_HOLD:   begin state_d = D_SETUP;  cnt_d = CNTW'(T_SETUP - 1);  end
            D_SETUP:  begin state_d = D_STROBE; cnt_d = CNTW'(T_STROBE - 1); end
            D_STROBE: begin state_d = D_HOLD;   cnt_d = CNTW'(T_HOLD - 1);   end
            D_HOLD:   begin state_d = GAP;      cnt_d = CNTW'(T_GAP - 1);    end
            default: begin
              if (idx_next_ext < n_q) begin
                state_d = A_SETUP;
                cnt_d   = CNTW'(T_SETUP - 1);
                idx_d   = idx_q + IW'(1);
              end else begin
                state_d = DONE;
              end
            end
          endcase
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Bus outputs are decoded from the next state so that they appear registered
  // in the same cycle the FSM enters each state.
  always_comb begin
    addr_d   = base_d + DW'(idx_d);
    slot_d   = wdata_d[int'(idx_d)*DW +: DW];
    cs_d     = 1'b1;
    wr_n_d   = 1'b1;
    rd_n_d   = 1'b1;
    ad_d     = 1'b1;
    pullup_d = 1'b0;
    adout_d  = '0;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    case (state_d)
      A_SETUP, A_STROBE, A_HOLD: begin
        cs_d     = 1'b0;
        busy_d   = 1'b1;
        ad_d     = 1'b0;
        pullup_d = 1'b1;
        adout_d  = addr_d;
        wr_n_d   = (state_d != A_STROBE);
      end
      D_SETUP, D_STROBE, D_HOLD: begin
        cs_d   = 1'b0;
        busy_d = 1'b1;
        if (dir_wr_d) begin
          pullup_d = 1'b1;
          adout_d  = slot_d;
          wr_n_d   = (state_d != D_STROBE);
        end else begin
          rd_n_d = (state_d != D_STROBE);
        end
      end
      GAP:     busy_d = 1'b1;
      DONE:    done_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      n_q      <= '0;
      dir_wr_q <= 1'b0;
      base_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      cs_q     <= 1'b1;
      wr_n_q   <= 1'b1;
      rd_n_q   <= 1'b1;
      ad_q     <= 1'b1;
      pullup_q <= 1'b0;
      adout_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      n_q      <= n_d;
      dir_wr_q <= dir_wr_d;
      base_q   <= base_d;
      wdata_q  <= wdata_d;
      cs_q     <= cs_d;
      wr_n_q   <= wr_n_d;
      rd_n_q   <= rd_n_d;
      ad_q     <= ad_d;
      pullup_q <= pullup_d;
      adout_q  <= adout_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      // Sample ADin on the last strobe cycle, while RD is still low.
      if ((state_q == D_STROBE) && (cnt_q == '0) && !dir_wr_q) begin
        rdata_q[int'(idx_q)*DW +: DW] <= ADin;
      end
    end
  end

  assign rdata  = rdata_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign ADout  = adout_q;
  assign Pullup = pullup_q;
  assign AD     = ad_q;
  assign WR     = wr_n_q;
  assign RD     = rd_n_q;
  assign CS     = cs_q;

endmodule

// File: tb/tb_rtc_bus_burst.sv
// Directed testbench for rtc_bus_burst with default parameters
// (DW=8, NREG=4, per-register period 18 cycles).
module tb_rtc_bus_burst;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        wr_nrd;
  logic [7:0]  base_addr;
  logic [2:0]  count;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        busy, done;
  logic [7:0]  ADin, ADout;
  logic        Pullup, AD, WR, RD, CS;

  rtc_bus_burst dut (
    .clk(clk), .rst(rst), .start(start), .wr_nrd(wr_nrd),
    .base_addr(base_addr), .count(count), .wdata(wdata), .rdata(rdata),
    .busy(busy), .done(done), .ADin(ADin), .ADout(ADout), .Pullup(Pullup),
    .AD(AD), .WR(WR), .RD(RD), .CS(CS)
  );

  always #5 clk = ~clk;

  // RTC model: latches the address on the address strobe, returns 0xA0+addr.
  logic [7:0] addr_lat = 8'h00;
  always @(posedge clk) if (!CS && !AD && !WR) addr_lat <= ADout;
  assign ADin = 8'hA0 + addr_lat;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Bus monitor, sampled on the falling edge.
  logic [7:0] addr_q[$];
  logic [7:0] data_q[$];
  int  frames = 0, bad_inv = 0, bad_pull = 0;
  logic exp_wr = 1'b0;
  logic prev_cs = 1'b1, prev_wr = 1'b1;

  always @(negedge clk) begin
    if (prev_cs && !CS) frames++;
    if (prev_wr && !WR) begin
      if (!AD) addr_q.push_back(ADout);
      else     data_q.push_back(ADout);
    end
    if ((!WR && !RD) || (CS && (!WR || !RD))) bad_inv++;
    if (!CS && AD && ((Pullup !== exp_wr) || (!exp_wr && ADout != 8'h00))) bad_pull++;
    if (!CS && !AD && (Pullup !== 1'b1)) bad_pull++;
    prev_cs = CS;
    prev_wr = WR;
  end

  task automatic clear_mon(input logic w);
    addr_q.delete();
    data_q.delete();
    frames   = 0;
    bad_pull = 0;
    exp_wr   = w;
  endtask

  // Issue a start at the next edge (edge k). done_c is the number of cycles
  // after edge k at which done is first seen high (-1 on timeout).
  task automatic run_burst(input logic w, input logic [7:0] base, input logic [2:0] cnt,
                           input logic [31:0] wd, output int done_c, output int busy_seen);
    clear_mon(w);
    wr_nrd = w; base_addr = base; count = cnt; wdata = wd;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    done_c = -1;
    busy_seen = 0;
    for (int c = 0; c < 200; c++) begin
      if (busy) busy_seen = 1;
      if (done) begin
        done_c = c;
        break;
      end
      @(posedge clk); #1;
    end
    $display("burst wr=%0d base=0x%02h count=%0d frames=%0d done_c=%0d rdata=0x%08h",
             w, base, cnt, frames, done_c, rdata);
  endtask

  int dc, bs;

  initial begin
    rst = 1'b1; start = 1'b0; wr_nrd = 1'b0; base_addr = 8'h00; count = 3'd0; wdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check_val("reset_ctrl", {CS, WR, RD, AD, Pullup, busy, done}, 7'b1111000);
    check_val("reset_adout", ADout, 8'h00);
    check_val("reset_rdata", rdata, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Write burst, 3 registers
    run_burst(1'b1, 8'h21, 3'd3, 32'h00563412, dc, bs);
    check_val("wr3_done", dc, 54);
    check_val("wr3_frames", frames, 3);
    check_val("wr3_addr", {addr_q[0], addr_q[1], addr_q[2]}, 24'h212223);
    check_val("wr3_data", {data_q[0], data_q[1], data_q[2]}, 24'h123456);
    check_val("wr3_pullup", bad_pull, 0);
    check_val("wr3_rdata", rdata, 32'h0);
    @(posedge clk); #1;
    check_val("done_pulse", {done, busy}, 2'b00);

    // Read burst, 4 registers
    run_burst(1'b0, 8'h41, 3'd4, 32'h0, dc, bs);
    check_val("rd4_done", dc, 72);
    check_val("rd4_frames", frames, 4);
    check_val("rd4_rdata", rdata, 32'hE4E3E2E1);
    check_val("rd4_pullup", bad_pull, 0);

    // Zero-length burst: back-to-back start accepted in the DONE cycle
    run_burst(1'b1, 8'h10, 3'd0, 32'h0, dc, bs);
    check_val("n0_done", dc, 0);
    check_val("n0_busy", bs, 0);
    @(posedge clk); #1;
    check_val("n0_after", {done, busy, CS}, 3'b001);
    check_val("n0_frames", frames, 0);

    // count above NREG saturates to 4 registers
    run_burst(1'b1, 8'h30, 3'd7, 32'h44332211, dc, bs);
    check_val("n7_done", dc, 72);
    check_val("n7_frames", frames, 4);
    check_val("n7_last", {addr_q[3], data_q[3]}, 16'h3344);

    // Read aborted by reset during D_STROBE of register 1, with an ignored start
    clear_mon(1'b0);
    wr_nrd = 1'b0; base_addr = 8'h50; count = 3'd3;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 29; c++) begin
      if (c == 3) begin
        start = 1'b1; wr_nrd = 1'b1; base_addr = 8'h70; count = 3'd1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
    end
    check_val("abort_rd_low", {CS, RD, AD}, 3'b001);
    check_val("abort_rdata_pre", rdata, 32'hE4E3E2F0);
    check_val("abort_addr1", addr_q[1], 8'h51);
    check_val("abort_pullup", bad_pull, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    $display("reset mid-burst CS=%0d WR=%0d RD=%0d busy=%0d rdata=0x%08h", CS, WR, RD, busy, rdata);
    check_val("abort_ctrl", {CS, WR, RD, AD, Pullup, busy, done}, 7'b1111000);
    check_val("abort_rdata", rdata, 32'h0);
    rst = 1'b0;
    bs = 0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      if (done || busy) bs = 1;
    end
    check_val("abort_no_done", bs, 0);

    // Address wrap, write 2 registers
    run_burst(1'b1, 8'hFF, 3'd2, 32'h0000BBAA, dc, bs);
    check_val("wrap_done", dc, 36);
    check_val("wrap_addr", {addr_q[0], addr_q[1]}, 16'hFF00);
    check_val("wrap_data", {data_q[0], data_q[1]}, 16'hAABB);

    check_val("bus_invariants", bad_inv, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
